// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC sequencer: FSM state encoding and default vectors.
package pc_seq_pkg;

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_ISR  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam logic [15:0] DEF_IRQ_VEC   = 16'h0010;
  localparam logic [15:0] DEF_INC       = 16'h0001;

endpackage

// File: rtl/pc_sequencer_if.sv
// Core-side request/response bundle between the pipeline and the PC sequencer.
interface pc_sequencer_if;

  logic [15:0] pc_q;
  logic        stall;
  logic        jump;
  logic [15:0] jump_addr;
  logic        branch_taken;
  logic [15:0] branch_off;
  logic        reti;
  logic        halt;
  logic        irq;
  logic [15:0] pc_next;
  logic        irq_ack;
  logic [15:0] epc;
  logic        in_isr;
  logic        halted;

  modport master (
    output pc_q, stall, jump, jump_addr, branch_taken, branch_off, reti, halt, irq,
    input  pc_next, irq_ack, epc, in_isr, halted
  );

  modport slave (
    input  pc_q, stall, jump, jump_addr, branch_taken, branch_off, reti, halt, irq,
    output pc_next, irq_ack, epc, in_isr, halted
  );

endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Combinational next-PC selection: sequential/branch adders and the priority mux.
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [15:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [15:0] INC       = DEF_INC
) (
  input  logic        rst_n,
  input  logic [15:0] pc_q,
  input  logic [15:0] epc,
  input  logic [15:0] jump_addr,
  input  logic [15:0] branch_off,
  input  logic        in_halt,
  input  logic        stall,
  input  logic        accept,
  input  logic        reti_sel,
  input  logic        halt_run,
  input  logic        jump,
  input  logic        branch_taken,
  output logic [15:0] pc_next,
  output logic [15:0] ret_target
);

  logic [15:0] seq;
  logic [15:0] br_target;

  always_comb begin
    seq       = pc_q + INC;
    br_target = seq + branch_off;

    // Target the flow would take with no irq and no reti; it becomes epc on accept.
    ret_target = seq;
    if (!in_halt && !halt_run) begin
      if (jump)              ret_target = jump_addr;
      else if (branch_taken) ret_target = br_target;
    end

    if (!rst_n)        pc_next = RESET_VEC;
    else if (in_halt)  pc_next = accept ? IRQ_VEC : pc_q;
    else if (stall)    pc_next = pc_q;
    else if (accept)   pc_next = IRQ_VEC;
    else if (reti_sel) pc_next = epc;
    else               pc_next = ret_target;
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: RUN/ISR/HALT control FSM with saved return address and irq acknowledge.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [15:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [15:0] INC       = DEF_INC
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  // state   | meaning
  // ST_RUN  | normal sequential/jump/branch flow, irq accepted
  // ST_ISR  | handler running, irq masked until reti
  // ST_HALT | PC parked after halt, only irq or reset leaves

  logic [1:0]  state_q, state_d;
  logic [15:0] epc_q, epc_d;
  logic        irq_ack_q, irq_ack_d;
  logic [15:0] ret_target;
  logic [15:0] pc_next_w;
  logic        accept, reti_sel, halt_run;

  assign accept   = bus.irq && !bus.stall && (state_q == ST_RUN || state_q == ST_HALT);
  assign reti_sel = bus.reti && (state_q == ST_ISR);
  assign halt_run = bus.halt && (state_q == ST_RUN);

  pc_target_calc #(
    .RESET_VEC (RESET_VEC),
    .IRQ_VEC   (IRQ_VEC),
    .INC       (INC)
  ) u_target_calc (
    .rst_n        (rst),
    .pc_q         (bus.pc_q),
    .epc          (epc_q),
    .jump_addr    (bus.jump_addr),
    .branch_off   (bus.branch_off),
    .in_halt      (state_q == ST_HALT),
    .stall        (bus.stall),
    .accept       (accept),
    .reti_sel     (reti_sel),
    .halt_run     (halt_run),
    .jump         (bus.jump),
    .branch_taken (bus.branch_taken),
    .pc_next      (pc_next_w),
    .ret_target   (ret_target)
  );

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    irq_ack_d = accept;
    if (!bus.stall) begin
      case (state_q)
        ST_RUN:  if (accept) state_d = ST_ISR;
                 else if (bus.halt) state_d = ST_HALT;
        ST_ISR:  if (bus.reti) state_d = ST_RUN;
        ST_HALT: if (accept) state_d = ST_ISR;
        default: state_d = ST_RUN;
      endcase
    end
    if (accept) epc_d = ret_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      epc_q     <= 16'h0000;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign bus.pc_next = pc_next_w;
  assign bus.irq_ack = irq_ack_q;
  assign bus.epc     = epc_q;
  assign bus.in_isr  = (state_q == ST_ISR);
  assign bus.halted  = (state_q == ST_HALT);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter RESET_VEC, 16'h0000, the pc_next value driven during reset.
REQ-003 Parameter IRQ_VEC, 16'h0010, the interrupt handler entry address.
REQ-004 Parameter INC, 16'h0001, the sequential PC increment.
REQ-005 Port clk  in  1  system clock, rising edge.
REQ-006 Port rst  in  1  asynchronous active-low reset.
REQ-007 Port pc_q  in  16  current PC from the PC register.
REQ-008 Port stall  in  1  hold the PC this cycle.
REQ-009 Port jump  in  1  absolute jump request.
REQ-010 Port jump_addr  in  16  jump target.
REQ-011 Port branch_taken  in  1  resolved conditional branch.
REQ-012 Port branch_off  in  16  signed two's-complement branch offset.
REQ-013 Port reti  in  1  return-from-interrupt request.
REQ-014 Port halt  in  1  halt-instruction decode.
REQ-015 Port irq  in  1  level-sensitive interrupt request.
REQ-016 Port pc_next  out  16  next PC to the PC register.
REQ-017 Port irq_ack  out  1  one-cycle interrupt-accept pulse.
REQ-018 Port epc  out  16  saved return address.
REQ-019 Port in_isr  out  1  high while the handler runs.
REQ-020 Port halted  out  1  high in the HALT state.

Function
REQ-021 The FSM SHALL have three states: RUN, ISR and HALT.
REQ-022 Sequential target seq = pc_q + INC. Branch target = pc_q + INC + branch_off. All arithmetic SHALL be modulo 2^16, with silent wrap (16'hFFFF + 1 = 16'h0000).
REQ-023 pc_next SHALL be combinational. Priority from highest to lowest:
  - state HALT: pc_q
  - stall: pc_q
  - irq accept: IRQ_VEC
  - reti in ISR: epc
  - jump: jump_addr
  - branch_taken: branch target
  - otherwise: seq
REQ-024 Irq accept SHALL occur only when irq=1, stall=0 and the state is RUN or HALT.
REQ-025 On accept the block SHALL register epc from the target that would have been taken without the irq. In HALT that target is pc_q + INC. The next state SHALL be ISR.
REQ-026 irq_ack SHALL be registered: high exactly one cycle, the cycle after accept.
REQ-027 In ISR, irq SHALL be ignored (no nesting). reti SHALL select epc, and the next state SHALL be RUN.
REQ-028 When irq=1 and reti=1 in ISR, reti SHALL win. irq is then re-evaluated in RUN the next cycle (tail-chain), so re-entry occurs one cycle after return.
REQ-029 reti in RUN SHALL be ignored and treated as no request.
REQ-030 halt in RUN with stall=0 SHALL move the state to HALT with pc_next = seq, so the PC parks after the halt instruction. halt in ISR SHALL be ignored.
REQ-031 HALT SHALL exit only on irq accept or reset. jump, branch_taken and reti SHALL be ignored in HALT.
REQ-032 stall SHALL freeze state, epc and irq_ack generation. A pending irq SHALL wait until stall drops.
REQ-033 in_isr SHALL equal (state == ISR). halted SHALL equal (state == HALT). Both are registered.

Reset
REQ-034 While rst=0 the block SHALL drive:
  - pc_next = RESET_VEC
  - epc = 16'h0000
  - irq_ack = 0
  - state = RUN
  - in_isr = 0
  - halted = 0
REQ-035 Reset asserted mid-ISR or in HALT SHALL abandon the context. The first cycle after release SHALL behave as RUN with no pending ack.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the state encoding (RUN=2'b00, ISR=2'b01, HALT=2'b10) and the default vector constants.
REQ-037 Sub-module pc_target_calc SHALL hold the combinational seq/branch adders and the priority mux. The FSM and epc/ack registers SHALL stay in pc_sequencer.

Verification
REQ-038 Sequential run: pc_q=16'h0004, no requests -> pc_next=16'h0005.
REQ-039 Branch wrap: pc_q=16'hFFFE, branch_off=16'h0003, branch_taken=1 -> pc_next=16'h0002.
REQ-040 Interrupt entry and return:
  - pc_q=16'h0020, jump=1, jump_addr=16'h0100, irq=1 -> pc_next=16'h0010.
  - Next cycle: epc=16'h0100, irq_ack=1, in_isr=1.
  - Later reti=1 -> pc_next=16'h0100, in_isr=0 the following cycle.
REQ-041 Stall precedence: stall=1, irq=1, pc_q=16'h0030 -> pc_next=16'h0030, no ack. Drop stall -> accept that cycle.
REQ-042 Halt wake: halt at pc_q=16'h0040 -> halted=1, PC parks at 16'h0041. irq=1 -> pc_next=16'h0010, epc=16'h0042.
REQ-043 Reset mid-ISR: assert rst=0 while in_isr=1 -> pc_next=16'h0000, in_isr=0, epc=16'h0000 immediately, without waiting for a clock.
